// File: rtl/sram_slot_scheduler.sv
// rtl/sram_slot_scheduler.sv - Gigatron cycle slot scheduler for the shared expansion SRAM
module sram_slot_scheduler #(
   parameter int ABITS        = 19,
   parameter int STARVE_LIMIT = 64
) (
   input  logic             CLKx4,
   input  logic             RST,
   input  logic             SYNC,
   input  logic             HDBL,
   input  logic             VREQ,
   input  logic [ABITS-1:0] VADDR,
   output logic             VDATA_VLD,
   output logic [7:0]       VDATA,
   input  logic             DREQ,
   input  logic             DWE,
   input  logic [ABITS-1:0] DADDR,
   input  logic [7:0]       DWDATA,
   output logic             DACK,
   output logic [7:0]       DRDATA,
   output logic             DSTARVE,
   output logic             LOCKERR,
   output logic             nAE,
   output logic             nBE,
   output logic [1:0]       RSEL,
   output logic [ABITS-1:0] RAB,
   output logic             nROE_B,
   output logic             nRWE_B,
   input  logic [7:0]       RDIN,
   output logic [7:0]       RDOUT_B,
   output logic             RDOE_B
);

   typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_VID = 2'd1, OWN_DMA = 2'd2} owner_t;

   localparam int            CW      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   logic [1:0]       r_ph;
   logic             r_synced;
   owner_t           r_b1, r_b2;
   logic             r_dwr;
   logic [ABITS-1:0] r_vaddr, r_daddr;
   logic [7:0]       r_wdata, r_vdata, r_drdata;
   logic             r_vdata_vld, r_dack, r_dstarve, r_lockerr;
   logic [CW-1:0]    r_starve_cnt;

   owner_t           w_own, w_b1, w_b2;
   logic             w_a_phase, w_arb, w_abort, w_dma_grant;
   logic             w_cap_vid, w_cap_dread, w_dack_set;

   // Owner of the B phase currently on the bus (none outside PH2/PH3)
   always_comb begin
      w_own = OWN_NONE;
      if (r_ph == 2'd2)      w_own = r_b1;
      else if (r_ph == 2'd3) w_own = r_b2;
   end

   // Slot plan for the coming B1/B2 from this cycle's requests
   always_comb begin
      w_b1 = OWN_NONE;
      w_b2 = OWN_NONE;
      if (VREQ) begin
         w_b1 = OWN_VID;
         if (HDBL)              w_b2 = OWN_VID;
         else if (DREQ && !DWE) w_b2 = OWN_DMA;
      end else if (DREQ) begin
         w_b1 = OWN_DMA;
         if (DWE) w_b2 = OWN_DMA;
      end
   end

   assign w_a_phase   = r_synced && !r_ph[1];
   assign w_arb       = r_synced && (r_ph == 2'd1) && !SYNC;
   assign w_abort     = SYNC && (r_ph != 2'd3);
   assign w_dma_grant = (w_b1 == OWN_DMA) || (w_b2 == OWN_DMA);
   assign w_cap_vid   = !w_abort && (w_own == OWN_VID);
   assign w_cap_dread = !w_abort && (w_own == OWN_DMA) && !r_dwr;
   assign w_dack_set  = w_cap_dread || (!w_abort && (w_own == OWN_DMA) && r_dwr && (r_ph == 2'd3));

   // Bus-side strobes and address mux decoded from phase and slot owner
   always_comb begin
      nAE     = !w_a_phase;
      nBE     = (w_own == OWN_NONE);
      RSEL    = 2'd3;
      RAB     = '0;
      nROE_B  = 1'b1;
      nRWE_B  = 1'b1;
      RDOE_B  = 1'b0;
      if (w_a_phase) begin
         RSEL = 2'd0;
      end else if (w_own == OWN_VID) begin
         RSEL   = 2'd1;
         RAB    = r_vaddr;
         nROE_B = 1'b0;
      end else if (w_own == OWN_DMA) begin
         RSEL   = 2'd2;
         RAB    = r_daddr;
         nROE_B = r_dwr;
         RDOE_B = r_dwr;
         nRWE_B = !(r_dwr && (r_ph == 2'd3));
      end
   end

   assign RDOUT_B   = r_wdata;
   assign VDATA     = r_vdata;
   assign VDATA_VLD = r_vdata_vld;
   assign DRDATA    = r_drdata;
   assign DACK      = r_dack;
   assign DSTARVE   = r_dstarve;
   assign LOCKERR   = r_lockerr;

   // Phase counter, SYNC lock and off-phase detection
   always_ff @(posedge CLKx4 or posedge RST) begin
      if (RST) begin
         r_ph      <= 2'd0;
         r_synced  <= 1'b0;
         r_lockerr <= 1'b0;
      end else if (SYNC) begin
         r_ph     <= 2'd0;
         r_synced <= 1'b1;
         if (r_synced && (r_ph != 2'd3)) r_lockerr <= 1'b1;
      end else begin
         r_ph <= r_ph + 2'd1;
      end
   end

   // Grant latch at end of PH1; dropped after B2 or on any SYNC
   always_ff @(posedge CLKx4 or posedge RST) begin
      if (RST) begin
         r_b1    <= OWN_NONE;
         r_b2    <= OWN_NONE;
         r_dwr   <= 1'b0;
         r_vaddr <= '0;
         r_daddr <= '0;
         r_wdata <= 8'd0;
      end else if (SYNC || (r_ph == 2'd3)) begin
         r_b1 <= OWN_NONE;
         r_b2 <= OWN_NONE;
      end else if (w_arb) begin
         r_b1 <= w_b1;
         r_b2 <= w_b2;
         if (VREQ) r_vaddr <= VADDR;
         if (w_dma_grant) begin
            r_daddr <= DADDR;
            r_dwr   <= DWE;
            r_wdata <= DWDATA;
         end
      end
   end

   // Read-data capture and completion pulses at the end of each granted phase
   always_ff @(posedge CLKx4 or posedge RST) begin
      if (RST) begin
         r_vdata     <= 8'd0;
         r_vdata_vld <= 1'b0;
         r_drdata    <= 8'd0;
         r_dack      <= 1'b0;
      end else begin
         r_vdata_vld <= w_cap_vid;
         r_dack      <= w_dack_set;
         if (w_cap_vid)   r_vdata  <= RDIN;
         if (w_cap_dread) r_drdata <= RDIN;
      end
   end

   // DMA starvation counter: counts denied PH1 decisions, saturating flag
   always_ff @(posedge CLKx4 or posedge RST) begin
      if (RST) begin
         r_starve_cnt <= '0;
         r_dstarve    <= 1'b0;
      end else begin
         if (w_arb && DREQ) begin
            if (w_dma_grant) begin
               r_starve_cnt <= '0;
            end else if (r_starve_cnt != LIMIT_C) begin
               r_starve_cnt <= r_starve_cnt + ONE_C;
               if (r_starve_cnt == LIMIT_C - ONE_C) r_dstarve <= 1'b1;
            end
         end
         if (w_dack_set) r_dstarve <= 1'b0;
      end
   end

endmodule

// File: doc/sram_slot_scheduler.md
Name: sram_slot_scheduler

Overview:
- Cycle-level scheduler for the shared 512K SRAM on the Gigatron expansion board. Runs on CLKx4 and splits each Gigatron cycle into four phases.
- The two A phases always belong to the Gigatron bus port (nAE low).
- The two B phases are shared between the video fetch engine and a DMA requester (SPI/host copy engine).
- Produces nAE/nBE, B-slot address/strobes, the RAM address mux select, read-data capture and request/acknowledge handshakes.

Parameters:
- ABITS, 19, SRAM address width.
- STARVE_LIMIT, 64, consecutive Gigatron cycles a pending DMA request may be denied before DSTARVE sets.

Ports:
- CLKx4  in  1  scheduler clock (4x Gigatron clock); all state on rising edge.
- RST  in  1  reset, asynchronous, active-high.
- SYNC  in  1  phase marker, high for exactly one CLKx4 cycle per Gigatron cycle (CLK & CLKx2 sampled); the next cycle is phase 0.
- HDBL  in  1  video needs both B phases (double-pixel mode).
- VREQ  in  1  video wants a fetch this Gigatron cycle; sampled at phase 1.
- VADDR  in  ABITS  video fetch address; sampled with VREQ.
- VDATA_VLD  out  1  one-cycle pulse, VDATA valid.
- VDATA  out  8  video read data.
- DREQ  in  1  DMA request, level, held until DACK.
- DWE  in  1  DMA write (1) / read (0); held with DREQ.
- DADDR  in  ABITS  DMA address; held with DREQ.
- DWDATA  in  8  DMA write data; held with DREQ.
- DACK  out  1  one-cycle pulse, DMA access complete.
- DRDATA  out  8  DMA read data, valid at DACK, held until next DMA read.
- DSTARVE  out  1  sticky starvation flag; cleared by DACK.
- LOCKERR  out  1  sticky, SYNC arrived off-phase; cleared by RST only.
- nAE  out  1  low in phases 0-1.
- nBE  out  1  low during any granted B phase.
- RSEL  out  2  address mux select: 0 Gigatron, 1 video, 2 DMA, 3 idle.
- RAB  out  ABITS  B-slot address.
- nROE_B  out  1  B-slot read enable.
- nRWE_B  out  1  B-slot write enable.
- RDIN  in  8  SRAM data in.
- RDOUT_B  out  8  B-slot write data.
- RDOE_B  out  1  drive RDOUT_B onto the SRAM bus.

Behaviour:
- Reset values:
  - PH=0; nAE=1; nBE=1; RSEL=3; nROE_B=1; nRWE_B=1; RDOE_B=0; RAB=0.
  - VDATA_VLD=0; DACK=0; DSTARVE=0; LOCKERR=0; VDATA=0; DRDATA=0; starve counter=0.
  - No grant outstanding.
- Phase counter PH (2 bits):
  - Increments modulo 4 each cycle.
  - SYNC forces PH to 0 on the next cycle.
  - If SYNC is seen while PH!=3, set LOCKERR and resync anyway.
  - Before the first SYNC after reset, all outputs stay idle (free-running PH, no grants).
- Phases 0-1: nAE=0, RSEL=0; B outputs idle.
- Arbitration is decided at the end of phase 1 for the coming B1 (PH=2) and B2 (PH=3):
  - VREQ & HDBL: video gets B1 and B2. DMA denied.
  - VREQ & !HDBL: video gets B1. DMA read may take B2. DMA write denied (needs the full window).
  - !VREQ: DMA read takes B1; DMA write takes B1+B2.
- Video fetch:
  - RAB=VADDR latched; nROE_B=0; nBE=0 for each granted phase.
  - RDIN is captured at the end of each granted phase; each capture gives VDATA plus a VDATA_VLD pulse in the following cycle.
  - One pulse when not HDBL, two pulses when HDBL.
- DMA read:
  - One phase: nROE_B=0.
  - DRDATA captured at the phase end; DACK pulses the next cycle.
- DMA write:
  - B1: address only, RDOE_B=1, nROE_B=1.
  - B2: nRWE_B=0, RDOE_B=1.
  - nRWE_B returns high at the end of B2; DACK pulses the next cycle (phase 0).
- Only one DMA access per Gigatron cycle.
- A requester must not change DADDR/DWE/DWDATA while DREQ=1 and before DACK. DREQ dropped before a grant cancels it cleanly; after a grant, the access completes and DACK is still issued.
- Starvation counter:
  - Increments at each phase 1 where DREQ=1 and no DMA grant follows; resets on grant.
  - Reaching STARVE_LIMIT sets DSTARVE and saturates.
- SYNC arriving mid-B-access (off-phase):
  - Abort the access: strobes high next cycle, no DACK, no VDATA_VLD; DMA remains pending.
  - Set LOCKERR.
- nRWE_B and nROE_B are never low simultaneously. RDOE_B is low whenever nROE_B is low.

Test Plan:
- Reset mid-B2 DMA write -> nRWE_B=1 and RDOE_B=0 immediately (asynchronous), no DACK, LOCKERR=0.
- VREQ=1, HDBL=1, VADDR=0x12345, RDIN 0x2A then 0x15 -> nBE low in PH2-3, RAB=0x12345, two VDATA_VLD pulses with 0x2A then 0x15; a concurrent DREQ gets no DACK.
- VREQ=1, HDBL=0, DREQ read at 0x00100, RDIN=0x5A in PH3 -> video in PH2, RSEL=2 in PH3, DRDATA=0x5A with DACK in the next PH0.
- VREQ=0, DREQ write at 0x7FFFF with 0xC3 -> RDOE_B high PH2-3, nRWE_B low only in PH3, DACK in PH0, RDOUT_B=0xC3.
- VREQ=1, HDBL=1 continuously, DMA write pending, STARVE_LIMIT=4 -> DSTARVE=1 after the 4th denied cycle; drop VREQ -> write granted, DACK, DSTARVE=0.
- SYNC pulsed at PH=1 -> LOCKERR=1, PH=0 next cycle, no grants issued that cycle.
